pwm_demod: RTL and testbench
============================

PWM_DEMOD -- requirements
Module: pwm_demod

Interface
- REQ-001: Port clk, input, 1 bit; the single system clock; all state changes on its rising edge.
- REQ-002: Port nrst, input, 1 bit; reset is synchronous and active-low.
- REQ-003: Port en, input, 1 bit; capture enable; 0 forces IDLE.
- REQ-004: Port pwm_i, input, 1 bit; PWM stream from the synth pwm stage; 256-clk period, high while period count < sample.
- REQ-005: Port sample_o, output, 8 bits; last recovered sample value.
- REQ-006: Port valid_o, output, 1 bit; one-cycle strobe when sample_o updates.
- REQ-007: Port locked_o, output, 1 bit; 1 while aligned to the PWM period.
- REQ-008: Port err_o, output, 1 bit; one-cycle strobe on a detected period misalignment.
- REQ-009: Parameter PERIOD, default 256, PWM period in clk cycles; only 256 is supported.
- REQ-010: Parameter TIMEOUT, default 512, number of ALIGN cycles with no rising edge before a flat-level sample is reported.

Function
- REQ-011: pwm_i SHALL pass through a 2-flop synchronizer giving pwm_s; pwm_d SHALL be pwm_s delayed 1 cycle; rise = pwm_s & ~pwm_d.
- REQ-012: The FSM SHALL have states IDLE, ALIGN and MEASURE.
- REQ-013: IDLE -> ALIGN when en=1; any state -> IDLE on the cycle after en=0.
- REQ-014: In IDLE: period counter, accumulator and timeout counter = 0; locked_o = 0; sample_o holds its value.
- REQ-015: ALIGN -> MEASURE on the cycle rise=1; that cycle is period count 0; accumulator loads 1.
- REQ-016: In ALIGN, the timeout counter SHALL increment each cycle without rise.
- REQ-017: On the TIMEOUT-th cycle in ALIGN, sample_o <= (pwm_s ? 8'hFF : 8'h00) and valid_o pulses; the timeout counter then restarts and the FSM stays in ALIGN.
- REQ-018: In MEASURE, the 8-bit period counter SHALL increment every cycle and wrap 255 -> 0.
- REQ-019: In MEASURE, the 9-bit accumulator SHALL add pwm_s each cycle.
- REQ-020: On the cycle with count = 255: sample_o <= min(acc + pwm_s, 255); valid_o = 1 on the next cycle; accumulator restarts from 0 for count 0; locked_o <= 1.
- REQ-021: In MEASURE, rise with count != 0 SHALL: pulse err_o for 1 cycle; drop locked_o; discard the partial accumulator; treat that cycle as count 0 with accumulator loaded 1; not pulse valid_o.
- REQ-022: Rise at count = 0 is the expected alignment and SHALL cause no action.
- REQ-023: While locked, a period with no rise (sample 0) SHALL still produce sample_o = 0 with a valid_o pulse.
- REQ-024: Latency from a pwm_i change to pwm_s is 2 cycles; from the last cycle of a period at pwm_s to valid_o it is 1 cycle.
- REQ-025: Simultaneous en=0 and count=255 SHALL take the IDLE transition; no valid_o pulse.
- REQ-026: valid_o and err_o SHALL never be high on the same cycle.

Reset
- REQ-027: nrst=0 at a clk edge SHALL set state IDLE, sample_o=0, valid_o=0, locked_o=0, err_o=0, sync flops=0, and all counters=0.
- REQ-028: Reset mid-period SHALL discard the partial measurement; the first valid_o after release requires a fresh rise.

Verification
- REQ-029: en=1, pwm_i driven with sample 0x80 for 3 periods -> first valid_o about 256 cycles after the first rise, sample_o=0x80 each period, locked_o=1 after the first.
- REQ-030: Samples 0x01, 0xFF, 0x00 in consecutive aligned periods -> sample_o = 0x01, 0xFF, 0x00 in order, one valid_o per period.
- REQ-031: pwm_i held 1 from en=1 -> valid_o at cycle TIMEOUT with sample_o=0xFF, repeating every 512 cycles; pwm_i held 0 -> sample_o=0x00.
- REQ-032: Locked at 0x40, then insert an extra rise at count 100 -> err_o pulse, locked_o=0, no valid_o for that partial period, correct 0x40 on the next full period.
- REQ-033: en dropped at count 200 -> IDLE next cycle, locked_o=0, sample_o unchanged; re-enable -> realigns on the next rise.
- REQ-034: nrst asserted mid-MEASURE -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pwm_demod.sv
// PWM demodulator: recovers 8-bit sample values from a 256-clock PWM stream.
// Aligns on the PWM rising edge, integrates the high time per period, and flags misalignment.
module pwm_demod #(
   parameter int unsigned PERIOD  = 256,
   parameter int unsigned TIMEOUT = 512
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       en,
   input  logic       pwm_i,
   output logic [7:0] sample_o,
   output logic       valid_o,
   output logic       locked_o,
   output logic       err_o
);

   localparam int unsigned     TmoW    = $clog2(TIMEOUT);
   localparam logic [7:0]      LastCnt = 8'(PERIOD - 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StAlign, StMeasure} state_e;

   state_e          state_q, state_d;
   logic            sync1_q, sync1_d;
   logic            pwm_s_q, pwm_s_d;
   logic            pwm_d_q, pwm_d_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [8:0]      acc_q, acc_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [7:0]      sample_q, sample_d;
   logic            valid_q, valid_d;
   logic            locked_q, locked_d;
   logic            err_q, err_d;

   logic            rise;
   logic [8:0]      acc_sum;
   logic [7:0]      acc_sat;

   assign rise    = pwm_s_q & ~pwm_d_q;
   assign acc_sum = acc_q + {8'd0, pwm_s_q};
   // A full-high period sums to 256, which must clamp to 255.
   assign acc_sat = acc_sum[8] ? 8'hFF : acc_sum[7:0];

   always_comb begin
      sync1_d  = pwm_i;
      pwm_s_d  = sync1_q;
      pwm_d_d  = pwm_s_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      tmo_d    = tmo_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      locked_d = locked_q;
      err_d    = 1'b0;

      if (!en) begin
         state_d  = StIdle;
         cnt_d    = 8'd0;
         acc_d    = 9'd0;
         tmo_d    = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               state_d  = StAlign;
               cnt_d    = 8'd0;
               acc_d    = 9'd0;
               tmo_d    = '0;
               locked_d = 1'b0;
            end
            StAlign: begin
               if (rise) begin
                  // The rise cycle is count 0 and already contributes one high cycle.
                  state_d = StMeasure;
                  cnt_d   = 8'd1;
                  acc_d   = 9'd1;
                  tmo_d   = '0;
               end else if (tmo_q == TmoLast) begin
                  sample_d = {8{pwm_s_q}};
                  valid_d  = 1'b1;
                  tmo_d    = '0;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            StMeasure: begin
               if (rise && (cnt_q != 8'd0)) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  cnt_d    = 8'd1;
                  acc_d    = 9'd1;
               end else if (cnt_q == LastCnt) begin
                  sample_d = acc_sat;
                  valid_d  = 1'b1;
                  locked_d = 1'b1;
                  cnt_d    = 8'd0;
                  acc_d    = 9'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
                  acc_d = acc_sum;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q  <= StIdle;
         sync1_q  <= 1'b0;
         pwm_s_q  <= 1'b0;
         pwm_d_q  <= 1'b0;
         cnt_q    <= 8'd0;
         acc_q    <= 9'd0;
         tmo_q    <= '0;
         sample_q <= 8'd0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= sync1_d;
         pwm_s_q  <= pwm_s_d;
         pwm_d_q  <= pwm_d_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         tmo_q    <= tmo_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   assign sample_o = sample_q;
   assign valid_o  = valid_q;
   assign locked_o = locked_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod: table of aligned periods plus hand-built corner sequences.
// Expected event cycles: a period whose first drive step starts at cycle t validates at t+258.
module tb_pwm_demod;

   logic       clk;
   logic       nrst;
   logic       en;
   logic       pwm_i;
   logic [7:0] sample_o;
   logic       valid_o;
   logic       locked_o;
   logic       err_o;

   pwm_demod #(
      .PERIOD  (256),
      .TIMEOUT (512)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .en       (en),
      .pwm_i    (pwm_i),
      .sample_o (sample_o),
      .valid_o  (valid_o),
      .locked_o (locked_o),
      .err_o    (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] s;
      logic [7:0] exp;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int vs[$], vc[$], vl[$], ec[$], el[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge and logged.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (valid_o || err_o) chk("valid_err_exclusive", int'(valid_o & err_o), 0);
      if (valid_o) begin
         vs.push_back(int'(sample_o));
         vc.push_back(cyc);
         vl.push_back(int'(locked_o));
      end
      if (err_o) begin
         ec.push_back(cyc);
         el.push_back(int'(locked_o));
      end
   endtask

   task automatic clr();
      vs.delete(); vc.delete(); vl.delete(); ec.delete(); el.delete();
   endtask

   // Drives n cycles of the PWM waveform for sample s, period positions k0..k0+n-1.
   task automatic drive(input logic [7:0] s, input int n, input int k0);
      for (int k = k0; k < k0 + n; k++) begin
         pwm_i = (k < int'(s));
         step();
      end
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      en   = 1'b0;
      step();
      step();
      nrst = 1'b1;
      step();
      clr();
   endtask

   task automatic chk_v(input string nm, input int i, input int s, input int c, input int l);
      if (i >= vs.size()) begin
         chk({nm, " present"}, vs.size(), i + 1);
      end else begin
         chk({nm, " sample"}, vs[i], s);
         chk({nm, " cycle"}, vc[i], c);
         chk({nm, " locked"}, vl[i], l);
      end
   endtask

   vec_t tbl[8];
   int   t0, t1, t2, p, q, e;

   initial begin
      tbl[0] = '{8'h80, 8'h80};
      tbl[1] = '{8'h80, 8'h80};
      tbl[2] = '{8'h80, 8'h80};
      tbl[3] = '{8'h01, 8'h01};
      tbl[4] = '{8'hFF, 8'hFF};
      tbl[5] = '{8'h00, 8'h00};
      tbl[6] = '{8'h40, 8'h40};
      tbl[7] = '{8'h02, 8'h02};

      nrst  = 1'b0;
      en    = 1'b0;
      pwm_i = 1'b0;

      // Reset state
      do_reset();
      chk("reset sample_o", int'(sample_o), 0);
      chk("reset valid_o", int'(valid_o), 0);
      chk("reset locked_o", int'(locked_o), 0);
      chk("reset err_o", int'(err_o), 0);

      // Aligned stream from the table
      en = 1'b1;
      drive(8'h00, 3, 300);
      t0 = cyc;
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].s, 256, 0);
         if (i == 0) begin
            chk("first period locked_o", int'(locked_o), 0);
            chk("first period no valid", vs.size(), 0);
         end
      end
      drive(8'h00, 4, 0);
      chk("stream valid count", vs.size(), 8);
      chk("stream err count", ec.size(), 0);
      for (int i = 0; i < 8; i++) chk_v($sformatf("stream[%0d]", i), i, int'(tbl[i].exp),
                                        t0 + 258 + 256 * i, 1);

      // Extra rise at count 100 while locked on 0x40
      do_reset();
      en = 1'b1;
      drive(8'h00, 3, 300);
      t0 = cyc;
      drive(8'h40, 256, 0);
      drive(8'h40, 256, 0);
      p = cyc;
      drive(8'h40, 100, 0);
      q = cyc;
      drive(8'h40, 256, 0);
      drive(8'h40, 256, 0);
      drive(8'h00, 4, 0);
      chk("misalign err count", ec.size(), 1);
      if (ec.size() > 0) begin
         chk("misalign err cycle", ec[0], q + 3);
         chk("misalign err locked_o", el[0], 0);
      end
      chk("misalign valid count", vs.size(), 4);
      chk_v("misalign v0", 0, 8'h40, t0 + 258, 1);
      chk_v("misalign v1", 1, 8'h40, p + 2, 1);
      chk_v("misalign v2", 2, 8'h40, q + 258, 1);
      chk_v("misalign v3", 3, 8'h40, q + 514, 1);

      // en dropped at count 200, re-enable, then en dropped at count 255
      do_reset();
      en = 1'b1;
      drive(8'h00, 3, 300);
      t0 = cyc;
      drive(8'h40, 256, 0);
      drive(8'h40, 202, 0);
      en = 1'b0;
      drive(8'h40, 1, 202);
      chk("en drop locked_o", int'(locked_o), 0);
      chk("en drop sample_o", int'(sample_o), 8'h40);
      chk("en drop valid_o", int'(valid_o), 0);
      drive(8'h40, 53, 203);
      en = 1'b1;
      drive(8'h00, 3, 300);
      t2 = cyc;
      drive(8'h20, 256, 0);
      drive(8'h10, 256, 0);
      drive(8'h00, 1, 0);
      en = 1'b0;
      drive(8'h00, 3, 1);
      chk("en sequence valid count", vs.size(), 2);
      chk_v("en v0", 0, 8'h40, t0 + 258, 1);
      chk_v("en realign v1", 1, 8'h20, t2 + 258, 1);
      chk("en at 255 sample_o", int'(sample_o), 8'h20);
      chk("en at 255 locked_o", int'(locked_o), 0);

      // Flat-high then flat-low timeout reporting
      pwm_i = 1'b1;
      do_reset();
      for (int i = 0; i < 3; i++) step();
      e  = cyc;
      en = 1'b1;
      for (int i = 0; i < 1030; i++) step();
      chk("timeout high valid count", vs.size(), 2);
      chk_v("timeout high v0", 0, 8'hFF, e + 513, 0);
      chk_v("timeout high v1", 1, 8'hFF, e + 1025, 0);
      en    = 1'b0;
      pwm_i = 1'b0;
      for (int i = 0; i < 4; i++) step();
      clr();
      e  = cyc;
      en = 1'b1;
      for (int i = 0; i < 520; i++) step();
      chk("timeout low valid count", vs.size(), 1);
      chk_v("timeout low v0", 0, 8'h00, e + 513, 0);

      // Reset mid-measurement discards the partial period
      do_reset();
      en = 1'b1;
      drive(8'h00, 3, 300);
      drive(8'h40, 256, 0);
      drive(8'h40, 100, 0);
      chk("pre-reset locked_o", int'(locked_o), 1);
      nrst = 1'b0;
      drive(8'h40, 1, 100);
      chk("mid reset sample_o", int'(sample_o), 0);
      chk("mid reset valid_o", int'(valid_o), 0);
      chk("mid reset locked_o", int'(locked_o), 0);
      chk("mid reset err_o", int'(err_o), 0);
      nrst = 1'b1;
      clr();
      drive(8'h40, 155, 101);
      t1 = cyc;
      drive(8'h30, 256, 0);
      drive(8'h00, 4, 0);
      chk("post reset valid count", vs.size(), 1);
      chk_v("post reset v0", 0, 8'h30, t1 + 258, 1);
      chk("post reset err count", ec.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
